// File: rtl/hswap_sched_if.sv
// rtl/hswap_sched_if.sv - request/result bundle for the shared halfword-swap scheduler
//
// Purpose: groups the two requester channels, the result channel and the
//          status outputs of hswap_sched into one interface.
// Ports (signals):
//   a_valid/a_ready/a_data/a_passes  requester A handshake, operand, pass count
//   b_valid/b_ready/b_data/b_passes  requester B handshake, operand, pass count
//   out_valid/out_ready/out_data     result handshake and value
//   out_src                          result owner (0=A, 1=B)
//   busy, done_cnt                   status: RUN/DONE flag, completion count
// Modports: master = producer/consumer side, slave = scheduler side.
interface hswap_sched_if #(
  parameter int WIDTH  = 32,
  parameter int PASS_W = 3,
  parameter int CNT_W  = 16
);
  logic              a_valid;
  logic              a_ready;
  logic [WIDTH-1:0]  a_data;
  logic [PASS_W-1:0] a_passes;
  logic              b_valid;
  logic              b_ready;
  logic [WIDTH-1:0]  b_data;
  logic [PASS_W-1:0] b_passes;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_src;
  logic              busy;
  logic [CNT_W-1:0]  done_cnt;

  modport master (
    output a_valid, a_data, a_passes,
    output b_valid, b_data, b_passes,
    output out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src, busy, done_cnt
  );

  modport slave (
    input  a_valid, a_data, a_passes,
    input  b_valid, b_data, b_passes,
    input  out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src, busy, done_cnt
  );
endinterface

// File: rtl/hswap_sched.sv
// rtl/hswap_sched.sv - round-robin arbitrated, time-shared iterative halfword-swap unit
//
// Purpose: grants one of two requesters, applies the halfword swap to its
//          operand the requested number of times with a single swap
//          instance, then presents the result on a valid/ready channel.
// Ports:
//   clk      rising-edge clock
//   reset_l  asynchronous active-low reset
//   io       hswap_sched_if.slave: requester A/B channels, result channel,
//            busy and done_cnt status
module hswap_sched #(
  parameter int WIDTH  = 32,
  parameter int PASS_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset_l,
  hswap_sched_if.slave  io
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q;
  logic [PASS_W-1:0] count_q;
  logic              last_grant_q;  // 0=A, 1=B
  logic              out_src_q;
  logic [CNT_W-1:0]  done_cnt_q;

  logic              grant_b;
  logic              a_rdy, b_rdy, accept;
  logic [WIDTH-1:0]  sel_data;
  logic [PASS_W-1:0] sel_passes;

  function automatic logic [WIDTH-1:0] swap(input logic [WIDTH-1:0] x);
    return {x[HALF-1:0], x[WIDTH-1:HALF]};
  endfunction

  // Arbitration. When both request, B wins only if A was served last.
  // Readies are gated by reset_l so nothing is accepted while in reset.
  always_comb begin
    grant_b    = io.b_valid && (!io.a_valid || !last_grant_q);
    a_rdy      = reset_l && (state_q == IDLE) && io.a_valid && !grant_b;
    b_rdy      = reset_l && (state_q == IDLE) && grant_b;
    accept     = a_rdy || b_rdy;
    sel_data   = grant_b ? io.b_data   : io.a_data;
    sel_passes = grant_b ? io.b_passes : io.a_passes;
  end

  // State register
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (sel_passes == '0) ? DONE : RUN;
      RUN:  if (count_q == PASS_W'(1)) state_d = DONE;
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    io.a_ready   = a_rdy;
    io.b_ready   = b_rdy;
    io.out_valid = (state_q == DONE);
    io.busy      = (state_q != IDLE);
    io.out_data  = acc_q;
    io.out_src   = out_src_q;
    io.done_cnt  = done_cnt_q;
  end

  // Datapath: operand capture, one swap per RUN cycle, completion count
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      acc_q        <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      out_src_q    <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q        <= sel_data;
            count_q      <= sel_passes;
            out_src_q    <= grant_b;
            last_grant_q <= grant_b;
          end
        end
        RUN: begin
          acc_q   <= swap(acc_q);
          count_q <= count_q - PASS_W'(1);
        end
        DONE: begin
          if (io.out_ready) done_cnt_q <= done_cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
